kernel_stream_source: RTL and testbench
=======================================

// Module: kernel_stream_source
// PURPOSE
//   Producer end of the kernel valid/ready stream: on start, reads nwords words from an on-chip
//   buffer (fixed 1-cycle read latency) and drives them onto a kernel input port (odata/ovalid,
//   backpressured by oready). Sits between the input buffer and a kernelTop_* ivalid/iready/in port.
//   Sustains 1 word/cycle when oready is held high; no word is lost or duplicated under backpressure.
// PARAMETERS
//   STREAMW     32  data width of buffer word and output stream
//   ADDRW       10  buffer address width
//   CNTW        16  width of word-count input nwords
//   FIFO_DEPTH  4   output FIFO entries, power of 2, >= 4 (covers 2 in-flight reads at full rate)
// PORTS
//   clk        in   1        single clock, all logic on rising edge
//   rst        in   1        reset; synchronous, active-low (rst==0 resets)
//   start      in   1        one-cycle request to stream nwords words from address 0
//   nwords     in   CNTW     word count, sampled in the cycle start is accepted
//   busy       out  1        high from cycle after accepted start until done pulse inclusive
//   done       out  1        one-cycle pulse after last word handshaken on output
//   mem_rden   out  1        buffer read enable (registered)
//   mem_raddr  out  ADDRW    buffer read address (registered), valid with mem_rden
//   mem_rdata  in   STREAMW  buffer read data, valid exactly 1 cycle after mem_rden
//   ovalid     out  1        output word valid
//   oready     in   1        downstream (kernel iready) can accept
//   odata      out  STREAMW  output word
// BEHAVIOUR
//   Clock/reset: one clock; reset is synchronous and active-low.
//   Reset values: busy=0, done=0, mem_rden=0, mem_raddr=0, ovalid=0, odata=0; FIFO empty,
//     counters zero, pending-read flag cleared, state IDLE.
//   FSM: IDLE -(start & nwords!=0)-> RUN; IDLE -(start & nwords==0)-> DONE; RUN -(issued==nwords)->
//     DRAIN; DRAIN -(sent==nwords)-> DONE; DONE -> IDLE (done=1 for this one cycle).
//   start while not IDLE is ignored (no restart, no count change).
//   Read issue (RUN): mem_rden=1 next cycle iff issued<nwords and fifo_count+inflight < FIFO_DEPTH;
//     mem_raddr = issued[ADDRW-1:0] (wraps modulo 2^ADDRW); issued increments per read.
//   inflight = reads issued whose data has not yet been written to FIFO (0..2).
//   Return: 1 cycle after mem_rden, mem_rdata written to FIFO tail; credit rule guarantees no
//     overflow, so a write to a full FIFO never occurs (assertion).
//   Output: ovalid = FIFO non-empty; odata = FIFO head; head popped and sent++ when ovalid&oready.
//     odata/ovalid stable while ovalid & !oready (AXI-style hold rule).
//   Simultaneous FIFO push and pop: count unchanged, both take effect.
//   Latency: start at cycle 0 -> mem_rden cycle 1 (addr 0) -> data in FIFO end of cycle 2 ->
//     ovalid=1 in cycle 3. With oready=1, words leave on consecutive cycles.
//   Last handshake in cycle k -> done=1, busy=1 in cycle k+1; busy=0 from cycle k+2.
//   nwords==0: done pulses in cycle 2, no mem_rden, no ovalid.
//   Reset mid-operation: everything returns to reset values on the next edge; read data returning
//     in the cycle after reset is discarded (pending flag cleared); start in that cycle is accepted.
// STRUCTURE
//   Shared package: STREAMW default, FSM state encoding (IDLE/RUN/DRAIN/DONE, 2 bits),
//     FIFO_DEPTH minimum constant.
//   One sub-module: kernel_stream_fifo (sync FIFO, params W/DEPTH, push/pop/full/empty/count,
//     first-word visible on head, same sync active-low reset). FSM, counters, credit logic in top.
// TESTING
//   T1 nwords=8, buffer[i]=i+0x100, oready=1: mem_rden cycles 1..8, odata 0x100..0x107 cycles 3..10,
//      done in cycle 11, busy low from cycle 12.
//   T2 nwords=8, oready toggles 1,0,1,0...: all 8 words in order, none repeated, odata held
//      while ovalid&!oready, in-flight never exceeds FIFO space (no overflow assertion fires).
//   T3 nwords=5, oready=0 until cycle 20: exactly FIFO_DEPTH reads issued then mem_rden=0;
//      after oready=1, remaining reads resume, words 0..4 delivered, done one cycle after last.
//   T4 nwords=0: no mem_rden, no ovalid, done=1 in cycle 2; start pulsed during busy of an
//      nwords=3 run is ignored (exactly 3 words, one done).
//   T5 nwords=2^ADDRW+2: mem_raddr wraps to 0 after max address; count of handshakes equals nwords.
//   T6 rst=0 asserted in cycle 6 of an nwords=16 run: all outputs at reset values next cycle,
//      returning read data discarded; fresh start then yields 16 clean words from address 0.

Source files
------------

// File: rtl/kernel_stream_source_pkg.sv
// Shared types and constants for the kernel stream producer.
package kernel_stream_source_pkg;

  localparam int STREAMW_DEF    = 32;
  localparam int FIFO_DEPTH_MIN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/kernel_stream_fifo.sv
// Small synchronous FIFO; head word is visible combinationally while non-empty.
module kernel_stream_fifo
  import kernel_stream_source_pkg::*;
#(
  parameter int W     = STREAMW_DEF,
  parameter int DEPTH = FIFO_DEPTH_MIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // The producer's credit check must make this unreachable.
      assert (!(push && full));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/kernel_stream_source.sv
// Streams nwords buffer words (1-cycle read latency) onto a valid/ready port,
// with credit-limited read issue so the output FIFO can never overflow.
module kernel_stream_source
  import kernel_stream_source_pkg::*;
#(
  parameter int STREAMW    = STREAMW_DEF,
  parameter int ADDRW      = 10,
  parameter int CNTW       = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_MIN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nwords,
  output logic               busy,
  output logic               done,
  output logic               mem_rden,
  output logic [ADDRW-1:0]   mem_raddr,
  input  logic [STREAMW-1:0] mem_rdata,
  output logic               ovalid,
  input  logic               oready,
  output logic [STREAMW-1:0] odata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e             state;
  logic [CNTW-1:0]    nwords_q, issued, sent;
  logic               rd_pend;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic [STREAMW-1:0] fifo_head;
  logic               pop;
  logic [CW:0]        occ;
  logic               can_issue;

  kernel_stream_fifo #(.W(STREAMW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .wdata (mem_rdata),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ovalid = !fifo_empty;
  assign odata  = fifo_empty ? '0 : fifo_head;
  assign pop    = ovalid && oready;

  // Pops are not credited: a slot is reserved until the word has left the FIFO.
  assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, mem_rden} + {{CW{1'b0}}, rd_pend};
  assign can_issue = (issued < nwords_q) && !fifo_full && (occ < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rden  <= 1'b0;
      mem_raddr <= '0;
      rd_pend   <= 1'b0;
      nwords_q  <= '0;
      issued    <= '0;
      sent      <= '0;
    end else begin
      rd_pend  <= mem_rden;
      mem_rden <= 1'b0;
      if (pop) sent <= sent + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            nwords_q <= nwords;
            issued   <= '0;
            sent     <= '0;
            busy     <= 1'b1;
            if (nwords != '0) begin
              state     <= ST_RUN;
              mem_rden  <= 1'b1;
              mem_raddr <= '0;
              issued    <= CNTW'(1);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (issued == nwords_q) begin
            state <= ST_DRAIN;
          end else if (can_issue) begin
            mem_rden  <= 1'b1;
            mem_raddr <= issued[ADDRW-1:0];
            issued    <= issued + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop && (sent + 1'b1 == nwords_q)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // An empty request arrives here with done low and spends one extra cycle.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_stream_source.sv
// Directed bench for kernel_stream_source: buffer model returns addr+0x100 one cycle after rden.
module tb_kernel_stream_source;

  localparam int STREAMW    = 32;
  localparam int ADDRW      = 10;
  localparam int CNTW       = 16;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [CNTW-1:0]    nwords = '0;
  logic               busy, done, mem_rden, ovalid;
  logic [ADDRW-1:0]   mem_raddr;
  logic [STREAMW-1:0] mem_rdata = '0;
  logic               oready = 1'b0;
  logic [STREAMW-1:0] odata;

  int n_vec = 0;
  int n_err = 0;

  int rden_cnt, rden_first, rden_last, hs_cnt, hs_first, hs_last;
  int done_cnt, done_cyc, busy_low, hold_err, busy_bad, addr_bad, data_bad;
  int max_out, rden_at_rdy, ovalid_cnt, addr_1024;
  bit finished, prev_stall;
  logic [STREAMW-1:0] prev_data;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_rden ? (STREAMW'(mem_raddr) + 32'h100) : '0;

  kernel_stream_source #(
    .STREAMW(STREAMW), .ADDRW(ADDRW), .CNTW(CNTW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .nwords(nwords), .busy(busy), .done(done),
    .mem_rden(mem_rden), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .ovalid(ovalid), .oready(oready), .odata(odata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c, input int rdy_at);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return c >= rdy_at;
    endcase
  endfunction

  // Cycle 0 is the cycle in which start is driven; stats are gathered until busy drops after done.
  task automatic run_stream(input int n, input int mode, input int rdy_at, input int xstart);
    rden_cnt = 0; rden_first = -1; rden_last = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    done_cnt = 0; done_cyc = -1; busy_low = -1; hold_err = 0; busy_bad = 0; addr_bad = 0;
    data_bad = 0; max_out = 0; rden_at_rdy = -1; ovalid_cnt = 0; addr_1024 = -1;
    finished = 0; prev_stall = 0; prev_data = '0;
    start = 1'b1; nwords = CNTW'(n); oready = rdy(mode, 0, rdy_at);
    for (int c = 0; c < 3000 && !finished; c++) begin
      if (c == rdy_at) rden_at_rdy = rden_cnt;
      if (mem_rden) begin
        if (int'(mem_raddr) != (rden_cnt % 1024)) addr_bad++;
        if (rden_cnt == 1024) addr_1024 = int'(mem_raddr);
        if (rden_first < 0) rden_first = c;
        rden_last = c;
        rden_cnt++;
      end
      if (prev_stall && (!ovalid || odata !== prev_data)) hold_err++;
      if (ovalid) ovalid_cnt++;
      if (ovalid && oready) begin
        if (odata !== STREAMW'((hs_cnt % 1024) + 'h100)) data_bad++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
        hs_cnt++;
      end
      if (rden_cnt - hs_cnt > max_out) max_out = rden_cnt - hs_cnt;
      if (c >= 1 && done_cyc < 0 && !busy) busy_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc >= 0 && !done && !busy) begin
        busy_low = c;
        finished = 1;
      end
      prev_stall = ovalid && !oready;
      prev_data  = odata;
      if (!finished) begin
        tick();
        start  = (c + 1 == xstart);
        nwords = (c + 1 == xstart) ? CNTW'(7) : CNTW'(n);
        oready = rdy(mode, c + 1, rdy_at);
      end
    end
    start = 1'b0;
    chk("run_terminates", 64'(finished), 64'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rden", 64'(mem_rden), 0);
    chk("rst_raddr", 64'(mem_raddr), 0);
    chk("rst_ovalid", 64'(ovalid), 0);
    chk("rst_odata", 64'(odata), 0);
    rst = 1'b1;
    tick();

    // T1: full rate, 8 words
    run_stream(8, 0, 0, -1);
    chk("t1_rden_first", rden_first, 1);
    chk("t1_rden_last", rden_last, 8);
    chk("t1_rden_cnt", rden_cnt, 8);
    chk("t1_hs_first", hs_first, 3);
    chk("t1_hs_last", hs_last, 10);
    chk("t1_hs_cnt", hs_cnt, 8);
    chk("t1_data", data_bad, 0);
    chk("t1_addr", addr_bad, 0);
    chk("t1_done_cyc", done_cyc, 11);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_low", busy_low, 12);
    chk("t1_busy", busy_bad, 0);
    repeat (2) tick();

    // T2: oready toggling
    run_stream(8, 1, 0, -1);
    chk("t2_hs_cnt", hs_cnt, 8);
    chk("t2_data", data_bad, 0);
    chk("t2_hold", hold_err, 0);
    chk("t2_done_after_last", done_cyc, hs_last + 1);
    chk("t2_outstanding_le_depth", 64'(max_out <= FIFO_DEPTH), 1);
    chk("t2_done_cnt", done_cnt, 1);
    repeat (2) tick();

    // T3: stalled until cycle 20
    run_stream(5, 2, 20, -1);
    chk("t3_reads_while_stalled", rden_at_rdy, FIFO_DEPTH);
    chk("t3_rden_cnt", rden_cnt, 5);
    chk("t3_hs_first", hs_first, 20);
    chk("t3_hs_cnt", hs_cnt, 5);
    chk("t3_data", data_bad, 0);
    chk("t3_hold", hold_err, 0);
    chk("t3_done_after_last", done_cyc, hs_last + 1);
    repeat (2) tick();

    // T4a: empty request
    run_stream(0, 0, 0, -1);
    chk("t4_rden_cnt", rden_cnt, 0);
    chk("t4_ovalid_cnt", ovalid_cnt, 0);
    chk("t4_done_cyc", done_cyc, 2);
    chk("t4_busy_low", busy_low, 3);
    chk("t4_done_cnt", done_cnt, 1);
    repeat (2) tick();

    // T4b: start while busy is ignored
    run_stream(3, 0, 0, 2);
    chk("t4b_hs_cnt", hs_cnt, 3);
    chk("t4b_rden_cnt", rden_cnt, 3);
    chk("t4b_done_cnt", done_cnt, 1);
    chk("t4b_data", data_bad, 0);
    repeat (2) tick();

    // T5: address wrap
    run_stream(1026, 0, 0, -1);
    chk("t5_hs_cnt", hs_cnt, 1026);
    chk("t5_rden_cnt", rden_cnt, 1026);
    chk("t5_addr", addr_bad, 0);
    chk("t5_wrap_addr", addr_1024, 0);
    chk("t5_data", data_bad, 0);
    chk("t5_done_cyc", done_cyc, 1029);
    repeat (2) tick();

    // T6: reset in cycle 6 of a 16-word run, fresh start in the following cycle
    start = 1'b1; nwords = CNTW'(16); oready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("t6_busy", 64'(busy), 0);
    chk("t6_done", 64'(done), 0);
    chk("t6_rden", 64'(mem_rden), 0);
    chk("t6_raddr", 64'(mem_raddr), 0);
    chk("t6_ovalid", 64'(ovalid), 0);
    chk("t6_odata", 64'(odata), 0);
    rst = 1'b1;
    run_stream(16, 0, 0, -1);
    chk("t6_rden_first", rden_first, 1);
    chk("t6_hs_first", hs_first, 3);
    chk("t6_hs_cnt", hs_cnt, 16);
    chk("t6_data", data_bad, 0);
    chk("t6_addr", addr_bad, 0);
    chk("t6_done_cyc", done_cyc, 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
